receive_ethernet_packet: RTL and testbench

Receive-side counterpart of the Ethernet send path. Sits between the DM9000A RX interface and user logic. Requests an available frame, parses the 14-byte header (dest MAC, src MAC, EtherType) from 16-bit words and filters on destination address and EtherType. Accepted payload words are streamed to the user; rejected or errored frames are drained silently and a drop is reported.

---
 rtl/receive_ethernet_packet.sv | 175 +++++++++++++++++
 tb/tb_receive_ethernet_packet.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receive_ethernet_packet.sv
// Receive path for the DM9000A RX interface: requests a pending frame, parses the
// 14-byte Ethernet header, filters on destination MAC and EtherType, streams the
// accepted payload to user logic with one cycle of latency, and silently drains
// rejected, runt, oversize or errored frames. Each requested frame ends in
// exactly one good or drop pulse.
module receive_ethernet_packet #(
  parameter logic [15:0] ACCEPT_TYPE  = 16'h0800,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [10:0] MAX_WORDS    = 11'd760
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [47:0] own_mac_in,
  input  logic        rx_packet_avail_in,
  output logic        rx_req_out,
  input  logic [15:0] rx_data_in,
  input  logic        rx_data_valid_in,
  input  logic        rx_last_in,
  input  logic        rx_error_in,
  output logic [15:0] packet_data_out,
  output logic        packet_data_valid_out,
  output logic        packet_start_out,
  output logic        packet_end_out,
  output logic        packet_good_out,
  output logic        packet_drop_out,
  output logic [47:0] src_mac_out,
  output logic [15:0] eth_type_out,
  output logic [10:0] payload_words_out
);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StDrain,
    StDone
  } state_e;

  state_e      state_q;
  logic [2:0]  hdr_cnt_q;
  logic [10:0] word_cnt_q;
  logic        own_match_q;
  logic        bcast_match_q;

  logic [15:0] own_word;
  logic        dest_ok;
  logic        type_ok;
  logic [10:0] word_cnt_inc;

  // Slice of our own MAC that the current destination header word must equal.
  always_comb begin
    own_word = 16'h0000;
    case (hdr_cnt_q)
      3'd0:    own_word = own_mac_in[47:32];
      3'd1:    own_word = own_mac_in[31:16];
      3'd2:    own_word = own_mac_in[15:0];
      default: own_word = 16'h0000;
    endcase
  end

  // Filter decision, only meaningful while the EtherType word (w6) is on the bus.
  always_comb begin
    dest_ok      = own_match_q || (ACCEPT_BCAST && bcast_match_q);
    type_ok      = (rx_data_in == ACCEPT_TYPE);
    word_cnt_inc = (word_cnt_q == 11'h7FF) ? word_cnt_q : word_cnt_q + 11'd1;
  end

  // Frame FSM with all user-visible outputs registered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q               <= StIdle;
      hdr_cnt_q             <= 3'd0;
      word_cnt_q            <= 11'd0;
      own_match_q           <= 1'b0;
      bcast_match_q         <= 1'b0;
      rx_req_out            <= 1'b0;
      packet_data_out       <= 16'h0000;
      packet_data_valid_out <= 1'b0;
      packet_start_out      <= 1'b0;
      packet_end_out        <= 1'b0;
      packet_good_out       <= 1'b0;
      packet_drop_out       <= 1'b0;
      src_mac_out           <= 48'h0;
      eth_type_out          <= 16'h0000;
      payload_words_out     <= 11'd0;
    end else begin
      packet_data_valid_out <= 1'b0;
      packet_start_out      <= 1'b0;
      packet_end_out        <= 1'b0;
      packet_good_out       <= 1'b0;
      packet_drop_out       <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (rx_packet_avail_in) begin
            state_q       <= StHeader;
            rx_req_out    <= 1'b1;
            hdr_cnt_q     <= 3'd0;
            word_cnt_q    <= 11'd0;
            own_match_q   <= 1'b1;
            bcast_match_q <= 1'b1;
          end
        end

        StHeader: begin
          if (rx_data_valid_in) begin
            hdr_cnt_q <= hdr_cnt_q + 3'd1;
            case (hdr_cnt_q)
              3'd0, 3'd1, 3'd2: begin
                own_match_q   <= own_match_q && (rx_data_in == own_word);
                bcast_match_q <= bcast_match_q && (rx_data_in == 16'hFFFF);
              end
              3'd3:    src_mac_out[47:32] <= rx_data_in;
              3'd4:    src_mac_out[31:16] <= rx_data_in;
              3'd5:    src_mac_out[15:0]  <= rx_data_in;
              default: eth_type_out       <= rx_data_in;
            endcase
            if (rx_last_in) begin
              // Ending on w6 is a header-only frame; anything earlier is a runt.
              state_q           <= StDone;
              rx_req_out        <= 1'b0;
              payload_words_out <= 11'd0;
              if (hdr_cnt_q == 3'd6 && dest_ok && type_ok && !rx_error_in) begin
                packet_good_out <= 1'b1;
              end else begin
                packet_drop_out <= 1'b1;
              end
            end else if (hdr_cnt_q == 3'd6) begin
              state_q <= (dest_ok && type_ok) ? StPayload : StDrain;
            end
          end
        end

        StPayload: begin
          if (rx_data_valid_in) begin
            packet_data_out       <= rx_data_in;
            packet_data_valid_out <= 1'b1;
            packet_start_out      <= (word_cnt_q == 11'd0);
            word_cnt_q            <= word_cnt_inc;
            if (rx_last_in) begin
              // An errored frame still delivers its end word; drop tells the user to discard.
              packet_end_out    <= 1'b1;
              state_q           <= StDone;
              rx_req_out        <= 1'b0;
              payload_words_out <= word_cnt_inc;
              packet_good_out   <= !rx_error_in;
              packet_drop_out   <= rx_error_in;
            end else if (word_cnt_inc == MAX_WORDS) begin
              state_q <= StDrain;
            end
          end
        end

        StDrain: begin
          if (rx_data_valid_in && rx_last_in) begin
            state_q           <= StDone;
            rx_req_out        <= 1'b0;
            payload_words_out <= word_cnt_q;
            packet_drop_out   <= 1'b1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q    <= StIdle;
          rx_req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receive_ethernet_packet.sv
// Bench for receive_ethernet_packet: two instances (broadcast accepted / rejected)
// share one RX stimulus; a monitor collects user-side output and a frame-level
// model predicts what each frame should produce.
module tb_receive_ethernet_packet;

  localparam logic [47:0] OwnMac = 48'h0011_2233_4455;
  localparam logic [47:0] Bcast  = 48'hFFFF_FFFF_FFFF;
  localparam int          MaxW   = 760;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [47:0] own_mac_in = OwnMac;
  logic        rx_packet_avail_in = 1'b0;
  logic [15:0] rx_data_in = 16'h0;
  logic        rx_data_valid_in = 1'b0;
  logic        rx_last_in = 1'b0;
  logic        rx_error_in = 1'b0;

  logic        rx_req_out, packet_data_valid_out, packet_start_out, packet_end_out;
  logic        packet_good_out, packet_drop_out;
  logic [15:0] packet_data_out, eth_type_out;
  logic [47:0] src_mac_out;
  logic [10:0] payload_words_out;

  logic        nb_req, nb_valid, nb_start, nb_end, nb_good, nb_drop;
  logic [15:0] nb_data, nb_type;
  logic [47:0] nb_src;
  logic [10:0] nb_words;

  receive_ethernet_packet dut (
    .Clock(Clock), .Reset(Reset), .own_mac_in(own_mac_in),
    .rx_packet_avail_in(rx_packet_avail_in), .rx_req_out(rx_req_out),
    .rx_data_in(rx_data_in), .rx_data_valid_in(rx_data_valid_in),
    .rx_last_in(rx_last_in), .rx_error_in(rx_error_in),
    .packet_data_out(packet_data_out), .packet_data_valid_out(packet_data_valid_out),
    .packet_start_out(packet_start_out), .packet_end_out(packet_end_out),
    .packet_good_out(packet_good_out), .packet_drop_out(packet_drop_out),
    .src_mac_out(src_mac_out), .eth_type_out(eth_type_out),
    .payload_words_out(payload_words_out)
  );

  receive_ethernet_packet #(.ACCEPT_BCAST(1'b0)) dut_nb (
    .Clock(Clock), .Reset(Reset), .own_mac_in(own_mac_in),
    .rx_packet_avail_in(rx_packet_avail_in), .rx_req_out(nb_req),
    .rx_data_in(rx_data_in), .rx_data_valid_in(rx_data_valid_in),
    .rx_last_in(rx_last_in), .rx_error_in(rx_error_in),
    .packet_data_out(nb_data), .packet_data_valid_out(nb_valid),
    .packet_start_out(nb_start), .packet_end_out(nb_end),
    .packet_good_out(nb_good), .packet_drop_out(nb_drop),
    .src_mac_out(nb_src), .eth_type_out(nb_type), .payload_words_out(nb_words)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Monitor state
  logic [15:0] got_q[$];
  int          n_start, n_end, n_good, n_drop, first_out_cyc;
  logic [15:0] start_word, end_word;
  int          nbv_cnt, nbg_cnt, nbd_cnt;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (packet_data_valid_out) begin
        if (got_q.size() == 0) first_out_cyc = cyc;
        got_q.push_back(packet_data_out);
      end
      if (packet_data_valid_out && packet_start_out) begin
        n_start++;
        start_word = packet_data_out;
      end
      if (packet_data_valid_out && packet_end_out) begin
        n_end++;
        end_word = packet_data_out;
      end
      if (packet_good_out) n_good++;
      if (packet_drop_out) n_drop++;
      if (nb_valid) nbv_cnt++;
      if (nb_good) nbg_cnt++;
      if (nb_drop) nbd_cnt++;
    end
  end

  // Stimulus state
  logic [15:0] frame_q[$];
  logic [15:0] pay_q[$];
  bit          bubbles;
  bit          req_low;
  int          first_in_cyc;

  task automatic clear_mon();
    got_q = {};
    n_start = 0; n_end = 0; n_good = 0; n_drop = 0; first_out_cyc = -1;
    start_word = 16'h0; end_word = 16'h0;
    nbv_cnt = 0; nbg_cnt = 0; nbd_cnt = 0;
    req_low = 1'b0; first_in_cyc = -1;
  endtask

  task automatic make_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int n);
    frame_q = {d[47:32], d[31:16], d[15:0], s[47:32], s[31:16], s[15:0], t};
    pay_q = {};
    for (int i = 0; i < n; i++) pay_q.push_back(16'($urandom));
    foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
  endtask

  task automatic request();
    int k;
    rx_packet_avail_in = 1'b1;
    k = 0;
    do begin
      @(posedge Clock); #1;
      k++;
    end while (!rx_req_out && k < 20);
    rx_packet_avail_in = 1'b0;
    if (!rx_req_out) begin
      checks++; failures++;
      $display("FAIL request_timeout rx_req_out=%0b required=1", rx_req_out);
    end
  endtask

  task automatic drive_word(input logic [15:0] w, input bit last, input bit err, input int idx);
    if (bubbles) begin
      repeat ($urandom_range(0, 2)) begin
        rx_data_valid_in = 1'b0;
        rx_data_in = 16'($urandom);
        @(posedge Clock); #1;
      end
    end
    if (!rx_req_out) req_low = 1'b1;
    if (idx == 7 && first_in_cyc < 0) first_in_cyc = cyc;
    rx_data_in = w; rx_data_valid_in = 1'b1; rx_last_in = last; rx_error_in = err;
    @(posedge Clock); #1;
    rx_data_valid_in = 1'b0; rx_last_in = 1'b0; rx_error_in = 1'b0;
  endtask

  task automatic send_frame(input bit err);
    clear_mon();
    request();
    foreach (frame_q[i]) drive_word(frame_q[i], i == frame_q.size() - 1, err, i);
    repeat (6) @(posedge Clock);
    #1;
  endtask

  // Frame-level reference: filter, payload truncation and outcome.
  function automatic void model(input logic [47:0] d, input logic [15:0] t, input int n,
                                input bit err, input bit bc, output int n_emit,
                                output bit exp_end, output bit exp_good);
    bit acc;
    acc = (d == OwnMac || (bc && d == Bcast)) && t == 16'h0800;
    n_emit = acc ? ((n > MaxW) ? MaxW : n) : 0;
    exp_end = acc && n > 0 && n <= MaxW;
    exp_good = acc && !err && n <= MaxW;
  endfunction

  function automatic int word_errors(input int n);
    int e;
    e = (got_q.size() == n) ? 0 : 1;
    for (int i = 0; i < n && i < got_q.size(); i++) if (got_q[i] !== pay_q[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({rx_req_out, packet_data_valid_out, packet_start_out, packet_end_out,
         packet_good_out, packet_drop_out} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b required=000000", {rx_req_out, packet_data_valid_out,
               packet_start_out, packet_end_out, packet_good_out, packet_drop_out});
    end
    checks++;
    if ({src_mac_out, eth_type_out, payload_words_out, packet_data_out} !== 91'b0) begin
      failures++;
      $display("FAIL reset_data src=%h type=%h words=%0d data=%h required=all 0",
               src_mac_out, eth_type_out, payload_words_out, packet_data_out);
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_basic();
    bubbles = 1'b0;
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0800, 0);
    pay_q = {16'h1234, 16'h5678, 16'h9ABC};
    foreach (pay_q[i]) frame_q.push_back(pay_q[i]);
    send_frame(1'b0);
    checks++;
    if (word_errors(3) != 0) begin
      failures++; $display("FAIL basic_words got_n=%0d required_n=3", got_q.size());
    end
    checks++;
    if (n_start != 1 || start_word !== 16'h1234) begin
      failures++; $display("FAIL basic_start n=%0d word=%h required 1/1234", n_start, start_word);
    end
    checks++;
    if (n_end != 1 || end_word !== 16'h9ABC) begin
      failures++; $display("FAIL basic_end n=%0d word=%h required 1/9abc", n_end, end_word);
    end
    checks++;
    if (n_good != 1 || n_drop != 0) begin
      failures++; $display("FAIL basic_outcome good=%0d drop=%0d required 1/0", n_good, n_drop);
    end
    checks++;
    if (src_mac_out !== 48'h0A0B_0C0D_0E0F || eth_type_out !== 16'h0800) begin
      failures++; $display("FAIL basic_hdr src=%h type=%h", src_mac_out, eth_type_out);
    end
    checks++;
    if (payload_words_out !== 11'd3) begin
      failures++; $display("FAIL basic_count got=%0d required=3", payload_words_out);
    end
    checks++;
    if (first_out_cyc != first_in_cyc + 1) begin
      failures++;
      $display("FAIL basic_latency out_cyc=%0d required=%0d", first_out_cyc, first_in_cyc + 1);
    end
  endtask

  task automatic test_bcast();
    bubbles = 1'b1;
    make_frame(Bcast, 48'h0200_0000_0001, 16'h0800, 2);
    send_frame(1'b0);
    checks++;
    if (word_errors(2) != 0 || n_good != 1 || n_drop != 0) begin
      failures++;
      $display("FAIL bcast_accept n=%0d good=%0d drop=%0d required 2/1/0",
               got_q.size(), n_good, n_drop);
    end
    checks++;
    if (nbv_cnt != 0 || nbg_cnt != 0 || nbd_cnt != 1) begin
      failures++;
      $display("FAIL bcast_nobcast valid=%0d good=%0d drop=%0d required 0/0/1",
               nbv_cnt, nbg_cnt, nbd_cnt);
    end
  endtask

  task automatic test_filter();
    bubbles = 1'b1;
    make_frame(48'h0011_2233_4456, 48'h0A0B_0C0D_0E0F, 16'h0800, 4);
    send_frame(1'b0);
    checks++;
    if (got_q.size() != 0 || n_good != 0 || n_drop != 1 || req_low) begin
      failures++;
      $display("FAIL filter_dest valid=%0d good=%0d drop=%0d req_low=%0b required 0/0/1/0",
               got_q.size(), n_good, n_drop, req_low);
    end
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0806, 4);
    send_frame(1'b0);
    checks++;
    if (got_q.size() != 0 || n_good != 0 || n_drop != 1 || req_low) begin
      failures++;
      $display("FAIL filter_type valid=%0d good=%0d drop=%0d req_low=%0b required 0/0/1/0",
               got_q.size(), n_good, n_drop, req_low);
    end
  endtask

  task automatic test_runt();
    bubbles = 1'b0;
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0800, 3);
    while (frame_q.size() > 5) void'(frame_q.pop_back());
    send_frame(1'b0);
    checks++;
    if (got_q.size() != 0 || n_good != 0 || n_drop != 1 || rx_req_out !== 1'b0) begin
      failures++;
      $display("FAIL runt valid=%0d good=%0d drop=%0d req=%0b required 0/0/1/0",
               got_q.size(), n_good, n_drop, rx_req_out);
    end
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0800, 0);
    send_frame(1'b0);
    checks++;
    if (n_good != 1 || n_drop != 0 || n_start != 0 || n_end != 0 || payload_words_out !== 11'd0) begin
      failures++;
      $display("FAIL hdr_only good=%0d drop=%0d start=%0d end=%0d words=%0d required 1/0/0/0/0",
               n_good, n_drop, n_start, n_end, payload_words_out);
    end
  endtask

  task automatic test_error();
    bubbles = 1'b1;
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0800, 5);
    send_frame(1'b1);
    checks++;
    if (word_errors(5) != 0 || n_end != 1 || n_good != 0 || n_drop != 1) begin
      failures++;
      $display("FAIL error_frame n=%0d end=%0d good=%0d drop=%0d required 5/1/0/1",
               got_q.size(), n_end, n_good, n_drop);
    end
  endtask

  task automatic test_oversize();
    bubbles = 1'b0;
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0800, MaxW + 1);
    send_frame(1'b0);
    checks++;
    if (word_errors(MaxW) != 0 || n_end != 0 || n_good != 0 || n_drop != 1) begin
      failures++;
      $display("FAIL oversize n=%0d end=%0d good=%0d drop=%0d required 760/0/0/1",
               got_q.size(), n_end, n_good, n_drop);
    end
  endtask

  task automatic test_random();
    logic [47:0] d;
    logic [15:0] t;
    int n, n_emit, sel;
    bit err, exp_end, exp_good;
    bubbles = 1'b1;
    for (int f = 0; f < 10; f++) begin
      sel = $urandom_range(0, 3);
      d = (sel == 0) ? Bcast : (sel == 1) ? {OwnMac[47:1], ~OwnMac[0]} : OwnMac;
      t = ($urandom_range(0, 3) == 0) ? 16'h0806 : 16'h0800;
      n = $urandom_range(0, 12);
      err = ($urandom_range(0, 4) == 0);
      make_frame(d, {16'($urandom), 32'($urandom)}, t, n);
      send_frame(err);
      model(d, t, n, err, 1'b1, n_emit, exp_end, exp_good);
      checks++;
      if (word_errors(n_emit) != 0 || n_end != int'(exp_end) || n_start != int'(n_emit > 0)) begin
        failures++;
        $display("FAIL rand_words f=%0d n=%0d start=%0d end=%0d required n=%0d end=%0d",
                 f, got_q.size(), n_start, n_end, n_emit, exp_end);
      end
      checks++;
      if (n_good != int'(exp_good) || n_drop != int'(!exp_good)) begin
        failures++;
        $display("FAIL rand_outcome f=%0d good=%0d drop=%0d required good=%0d",
                 f, n_good, n_drop, exp_good);
      end
      if (exp_good) begin
        checks++;
        if (payload_words_out !== 11'(n)) begin
          failures++;
          $display("FAIL rand_count f=%0d got=%0d required=%0d", f, payload_words_out, n);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bubbles = 1'b0;
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0800, 5);
    clear_mon();
    request();
    for (int i = 0; i < 9; i++) drive_word(frame_q[i], 1'b0, 1'b0, i);
    rx_data_in = frame_q[9]; rx_data_valid_in = 1'b1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    rx_data_valid_in = 1'b0;
    checks++;
    if ({rx_req_out, packet_data_valid_out, packet_start_out, packet_end_out, packet_good_out,
         packet_drop_out} !== 6'b0 || {src_mac_out, eth_type_out, payload_words_out,
         packet_data_out} !== 91'b0) begin
      failures++;
      $display("FAIL reset_mid req=%0b valid=%0b src=%h data=%h required all 0",
               rx_req_out, packet_data_valid_out, src_mac_out, packet_data_out);
    end
    Reset = 1'b0;
    @(posedge Clock); #1;
    make_frame(OwnMac, 48'h0A0B_0C0D_0E0F, 16'h0800, 4);
    send_frame(1'b0);
    checks++;
    if (word_errors(4) != 0 || n_good != 1 || n_drop != 0 || payload_words_out !== 11'd4) begin
      failures++;
      $display("FAIL reset_recover n=%0d good=%0d drop=%0d words=%0d required 4/1/0/4",
               got_q.size(), n_good, n_drop, payload_words_out);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_bcast();
    test_filter();
    test_runt();
    test_error();
    test_oversize();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
